// File: rtl/aes_key_schedule.sv
// AES-128/192/256 key expansion: one 32-bit word per cycle into a 4*(NR+1) word store,
// with a registered, write-first round-key read port. Optional KEYEXP_ZEROIZE_EN adds zeroize/WIPE.
module aes_key_schedule #(
    parameter int KEY_BITS = 128
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start_i,
    input  logic [255:0] key_in_i,
`ifdef KEYEXP_ZEROIZE_EN
    input  logic         zeroize_i,
`endif
    output logic         ready_o,
    output logic         busy_o,
    output logic         done_o,
    input  logic         rd_en_i,
    input  logic [3:0]   rd_idx_i,
    output logic         rd_valid_o,
    output logic         rd_err_o,
    output logic [127:0] rd_key_o
);
    localparam int NK = KEY_BITS / 32;
    localparam int NR = NK + 6;
    localparam int NW = 4 * (NR + 1);

    if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
        $fatal(1, "aes_key_schedule: KEY_BITS must be 128, 192 or 256");
    end

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            p = p ^ (b[i] ? x : 8'h00);
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box as GF(2^8) inverse (x^254, inverse of 0 is 0) followed by the affine map
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] s;
        logic [7:0] r;
        s = a;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            s = gf_mul(s, s);
            r = gf_mul(r, s);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] idx);
        case (idx)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

`ifdef KEYEXP_ZEROIZE_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_EXPAND = 2'd1, S_WIPE = 2'd2} state_e;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_EXPAND = 2'd1} state_e;
`endif

    state_e        state_q, state_d;
    logic [5:0]    gen_cnt_q, gen_cnt_d;
    logic [2:0]    kpos_q, kpos_d;     // i % NK of the word being generated
    logic [3:0]    rci_q, rci_d;       // i / NK of the word being generated
    logic          done_q, done_d;
    logic          rd_valid_q, rd_err_q, rd_err_d;
    logic [127:0]  rd_key_q, rd_key_d;
    logic [31:0]   w_q [NW];
    logic [31:0]   key_w_s [8];
    logic [31:0]   prev_s, back_s, sub_s, temp_s, new_word_s;
    logic          load_s, exp_wr_s, zero_s;
`ifdef KEYEXP_ZEROIZE_EN
    logic [5:0]    wipe_idx_q, wipe_idx_d;
    logic          wipe_wr_s;
    assign zero_s = zeroize_i;
`else
    assign zero_s = 1'b0;
`endif

    // State and counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            gen_cnt_q <= 6'd0;
            kpos_q    <= 3'd0;
            rci_q     <= 4'd0;
            done_q    <= 1'b0;
`ifdef KEYEXP_ZEROIZE_EN
            wipe_idx_q <= 6'd0;
`endif
        end else begin
            state_q   <= state_d;
            gen_cnt_q <= gen_cnt_d;
            kpos_q    <= kpos_d;
            rci_q     <= rci_d;
            done_q    <= done_d;
`ifdef KEYEXP_ZEROIZE_EN
            wipe_idx_q <= wipe_idx_d;
`endif
        end
    end

    // Next-state and counter logic
    always_comb begin
        state_d   = state_q;
        gen_cnt_d = gen_cnt_q;
        kpos_d    = kpos_q;
        rci_d     = rci_q;
        done_d    = 1'b0;
`ifdef KEYEXP_ZEROIZE_EN
        wipe_idx_d = wipe_idx_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d   = S_EXPAND;
                    gen_cnt_d = 6'(NK);
                    kpos_d    = 3'd0;
                    rci_d     = 4'd1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_EXPAND: begin
                gen_cnt_d = gen_cnt_q + 6'd1;
                if (kpos_q == 3'(NK - 1)) begin
                    kpos_d = 3'd0;
                    rci_d  = rci_q + 4'd1;
                end else begin
                    kpos_d = kpos_q + 3'd1;
                end
                if (gen_cnt_q == 6'(NW - 1)) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_EXPAND;
                end
            end
`ifdef KEYEXP_ZEROIZE_EN
            S_WIPE: begin
                if (wipe_idx_q == 6'(NW - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    wipe_idx_d = wipe_idx_q + 6'd1;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
`ifdef KEYEXP_ZEROIZE_EN
        if (zero_s) begin
            state_d    = S_WIPE;
            gen_cnt_d  = 6'd0;
            wipe_idx_d = 6'd0;
            done_d     = 1'b0;
        end else begin
            wipe_idx_d = wipe_idx_d;
        end
`endif
    end

    // Status outputs and store write enables
    always_comb begin
        ready_o  = (state_q == S_IDLE);
        busy_o   = (state_q != S_IDLE);
        load_s   = (state_q == S_IDLE) && start_i && !zero_s;
        exp_wr_s = (state_q == S_EXPAND);
`ifdef KEYEXP_ZEROIZE_EN
        wipe_wr_s = (state_q == S_WIPE);
`endif
    end

    // Word generation datapath: one shared SubWord for both the RotWord and NK==8 cases
    always_comb begin
        for (int k = 0; k < 8; k++) begin
            key_w_s[k] = key_in_i[255 - 32 * k -: 32];
        end
        prev_s = w_q[gen_cnt_q - 6'd1];
        back_s = w_q[gen_cnt_q - 6'(NK)];
        sub_s  = sub_word((kpos_q == 3'd0) ? {prev_s[23:0], prev_s[31:24]} : prev_s);
        if (kpos_q == 3'd0) begin
            temp_s = sub_s ^ {rcon(rci_q), 24'h000000};
        end else if (NK == 8 && kpos_q == 3'd4) begin
            temp_s = sub_s;
        end else begin
            temp_s = prev_s;
        end
        new_word_s = back_s ^ temp_s;
    end

    // Word store (not reset)
    always_ff @(posedge clk) begin
        if (load_s) begin
            for (int k = 0; k < NK; k++) begin
                w_q[k] <= key_w_s[k];
            end
        end else if (exp_wr_s) begin
            w_q[gen_cnt_q] <= new_word_s;
`ifdef KEYEXP_ZEROIZE_EN
        end else if (wipe_wr_s) begin
            w_q[wipe_idx_q] <= 32'h0;
`endif
        end
    end

    // Read lookup: availability judged on the post-edge count, words written this edge forwarded
    always_comb begin
        logic [5:0]  j;
        logic [31:0] word;
        rd_err_d = (rd_idx_i > 4'(NR)) || ({rd_idx_i, 2'b11} >= gen_cnt_d);
        rd_key_d = 128'h0;
        for (int k = 0; k < 4; k++) begin
            j = {rd_idx_i, 2'b00} + 6'(k);
            if (load_s && j < 6'(NK)) begin
                word = key_w_s[j[2:0]];
            end else if (exp_wr_s && j == gen_cnt_q) begin
                word = new_word_s;
            end else begin
                word = w_q[j];
            end
            rd_key_d[127 - 32 * k -: 32] = word;
        end
        if (rd_err_d) begin
            rd_key_d = 128'h0;
        end else begin
            rd_key_d = rd_key_d;
        end
    end

    // Registered read port
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
            rd_key_q   <= 128'h0;
        end else begin
            rd_valid_q <= rd_en_i;
            rd_err_q   <= rd_en_i ? rd_err_d : 1'b0;
            rd_key_q   <= rd_en_i ? rd_key_d : 128'h0;
        end
    end

    assign done_o     = done_q;
    assign rd_valid_o = rd_valid_q;
    assign rd_err_o   = rd_err_q;
    assign rd_key_o   = rd_key_q;

endmodule

// File: tb/tb_aes_key_schedule.sv
// Scoreboard bench for aes_key_schedule: AES-128/192/256 instances checked against FIPS-197
// key-expansion vectors; the zeroize scenario is built only with KEYEXP_ZEROIZE_EN.
`timescale 1ns/1ps
module tb_aes_key_schedule;
    localparam logic [255:0] K128  = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] K128J = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'hdeadbeef_01234567_89abcdef_55aa55aa};
    localparam logic [255:0] KJUNK = 256'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0_11223344_55667788_99aabbcc_ddeeff00;
    localparam logic [255:0] K192  = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [255:0] K256  = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] R0_128  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] R1_128  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] R10_128 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] R0_192  = 128'h8e73b0f7da0e6452c810f32b809079e5;
    localparam logic [127:0] R12_192 = 128'he98ba06f448c773c8ecc720401002202;
    localparam logic [127:0] R0_256  = 128'h603deb1015ca71be2b73aef0857d7781;
    localparam logic [127:0] R1_256  = 128'h1f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] R14_256 = 128'hfe4890d1e6188d0b046df344706c631e;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic         start    [3];
    logic [255:0] key      [3];
    logic         rd_en    [3];
    logic [3:0]   rd_idx   [3];
    logic         ready    [3];
    logic         busy     [3];
    logic         done     [3];
    logic         rd_valid [3];
    logic         rd_err   [3];
    logic [127:0] rd_key   [3];
`ifdef KEYEXP_ZEROIZE_EN
    logic         zeroize  [3];
`endif

    for (genvar g = 0; g < 3; g++) begin : g_dut
        aes_key_schedule #(.KEY_BITS(128 + 64 * g)) u_dut (
            .clk        (clk),
            .reset      (reset),
            .start_i    (start[g]),
            .key_in_i   (key[g]),
`ifdef KEYEXP_ZEROIZE_EN
            .zeroize_i  (zeroize[g]),
`endif
            .ready_o    (ready[g]),
            .busy_o     (busy[g]),
            .done_o     (done[g]),
            .rd_en_i    (rd_en[g]),
            .rd_idx_i   (rd_idx[g]),
            .rd_valid_o (rd_valid[g]),
            .rd_err_o   (rd_err[g]),
            .rd_key_o   (rd_key[g])
        );
    end

    typedef struct {
        int           inst;
        logic         err;
        logic [127:0] key;
    } rd_exp_t;

    rd_exp_t sb_q [$];
    rd_exp_t mon_e;
    int checks   = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Scoreboard: every rd_valid pops the oldest expected read
    always @(negedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (rd_valid[g] === 1'b1) begin
                if (sb_q.size() == 0) begin
                    check_val("rd_unexpected", 128'(sb_q.size()), 128'd1);
                end else begin
                    mon_e = sb_q.pop_front();
                    check_val("rd_inst", 128'(g), 128'(mon_e.inst));
                    check_val("rd_err", 128'(rd_err[g]), 128'(mon_e.err));
                    check_val("rd_key", rd_key[g], mon_e.key);
                end
            end
        end
    end

    task automatic issue_read(input int g, input int idx, input logic err, input logic [127:0] k);
        rd_en[g]  = 1'b1;
        rd_idx[g] = 4'(idx);
        sb_q.push_back('{inst: g, err: err, key: (err ? 128'h0 : k)});
    endtask

    task automatic read_round(input int g, input int idx, input logic err, input logic [127:0] k);
        @(negedge clk);
        issue_read(g, idx, err, k);
        @(negedge clk);
        rd_en[g] = 1'b0;
    endtask

    // Drives start for one cycle (cycle T); returns in cycle T+1
    task automatic start_key(input int g, input logic [255:0] k);
        @(negedge clk);
        key[g]   = k;
        start[g] = 1'b1;
        @(negedge clk);
        start[g] = 1'b0;
    endtask

    task automatic wait_done(input int g, input int from_cycle, input int exp_cycle, input string tag);
        int n;
        n = from_cycle;
        while (done[g] !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_val(tag, 128'(n), 128'(exp_cycle));
        check_val({tag, "_ready"}, 128'(ready[g]), 128'd1);
        @(negedge clk);
        check_val({tag, "_pulse"}, 128'(done[g]), 128'd0);
    endtask

    initial begin
        int done_seen;
        int n;
        reset = 1'b1;
        for (int g = 0; g < 3; g++) begin
            start[g]  = 1'b0;
            key[g]    = 256'h0;
            rd_en[g]  = 1'b0;
            rd_idx[g] = 4'd0;
`ifdef KEYEXP_ZEROIZE_EN
            zeroize[g] = 1'b0;
`endif
        end
        repeat (3) @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            check_val("rst_ready", 128'(ready[g]), 128'd1);
            check_val("rst_busy", 128'(busy[g]), 128'd0);
        end
        check_val("rst_done", 128'(done[0]), 128'd0);
        check_val("rst_rd_valid", 128'(rd_valid[0]), 128'd0);
        check_val("rst_rd_err", 128'(rd_err[0]), 128'd0);
        check_val("rst_rd_key", rd_key[0], 128'h0);
        reset = 1'b0;

        // AES-128 vector
        start_key(0, K128);
        check_val("t1_busy", 128'(busy[0]), 128'd1);
        check_val("t1_ready", 128'(ready[0]), 128'd0);
        wait_done(0, 1, 41, "t1_done");
        read_round(0, 10, 1'b0, R10_128);
        read_round(0, 0, 1'b0, R0_128);
        read_round(0, 1, 1'b0, R1_128);
        read_round(0, 11, 1'b1, 128'h0);

        // Restart with junk key LSBs, reads during expansion, start while busy ignored
        start_key(0, K128J);
        @(negedge clk);
        issue_read(0, 10, 1'b1, 128'h0);
        @(negedge clk);
        issue_read(0, 0, 1'b0, R0_128);
        @(negedge clk);
        rd_en[0] = 1'b0;
        @(negedge clk);
        key[0]   = KJUNK;
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        wait_done(0, 6, 41, "t4_done");
        read_round(0, 10, 1'b0, R10_128);

        // AES-192 and AES-256 vectors
        start_key(1, K192);
        wait_done(1, 1, 47, "t2_done");
        read_round(1, 12, 1'b0, R12_192);
        read_round(1, 0, 1'b0, R0_192);
        read_round(1, 13, 1'b1, 128'h0);
        start_key(2, K256);
        wait_done(2, 1, 53, "t3_done");
        read_round(2, 14, 1'b0, R14_256);
        read_round(2, 1, 1'b0, R1_256);
        read_round(2, 0, 1'b0, R0_256);
        read_round(2, 15, 1'b1, 128'h0);

        // Start while busy, then reset mid-expansion
        start_key(0, K128);
        done_seen = 0;
        for (int c = 1; c <= 20; c++) begin
            if (done[0] === 1'b1) done_seen++;
            if (c == 5) begin
                key[0]   = KJUNK;
                start[0] = 1'b1;
            end
            if (c == 6) start[0] = 1'b0;
            if (c == 20) reset = 1'b1;
            @(negedge clk);
        end
        reset = 1'b0;
        check_val("t5_no_done", 128'(done_seen + int'(done[0])), 128'd0);
        check_val("t5_ready", 128'(ready[0]), 128'd1);
        check_val("t5_busy", 128'(busy[0]), 128'd0);
        read_round(0, 0, 1'b1, 128'h0);
        start_key(0, K128);
        wait_done(0, 1, 41, "t5_done");
        read_round(0, 10, 1'b0, R10_128);

`ifdef KEYEXP_ZEROIZE_EN
        // Zeroize wipes the store and invalidates all rounds
        @(negedge clk);
        zeroize[0] = 1'b1;
        @(negedge clk);
        zeroize[0] = 1'b0;
        n = 0;
        while (busy[0] === 1'b1 && n < 200) begin
            n++;
            @(negedge clk);
        end
        check_val("t6_wipe_cycles", 128'(n), 128'd44);
        read_round(0, 10, 1'b1, 128'h0);
        read_round(0, 0, 1'b1, 128'h0);
        start_key(0, K128);
        wait_done(0, 1, 41, "t6_done");
        read_round(0, 10, 1'b0, R10_128);
`else
        n = 0;
`endif

        repeat (3) @(negedge clk);
        check_val("sb_drain", 128'(sb_q.size()), 128'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
